// File: rtl/scr1_imem_trc_pkg.sv
// ---------------------------------------------------------------------------
// scr1_imem_trc_pkg
// Purpose : common widths and the log record layout for the IMEM command
//           tracer. Log consumers can overlay type_scr1_trc_rec_s on the
//           {log_addr, log_ts} pair when the default timestamp width is used.
// Contents: record widths, drop-counter width, record struct (no ports).
// ---------------------------------------------------------------------------
package scr1_imem_trc_pkg;

    localparam int SCR1_TRC_ADDR_W     = 32;
    localparam int SCR1_TRC_TS_W       = 16;
    localparam int LOG_REC_W           = SCR1_TRC_ADDR_W + SCR1_TRC_TS_W;
    localparam int SCR1_TRC_DROP_CNT_W = 8;

    typedef struct packed {
        logic [SCR1_TRC_ADDR_W-1:0] addr;
        logic [SCR1_TRC_TS_W-1:0]   ts;
    } type_scr1_trc_rec_s;

endpackage : scr1_imem_trc_pkg

// File: rtl/scr1_memif_pkg.sv
// ---------------------------------------------------------------------------
// scr1_memif_pkg
// Purpose : shared IMEM/DMEM interface encodings used by the core-side
//           memory interfaces and by anything that snoops them.
// Contents: response encoding enum only (no ports).
// ---------------------------------------------------------------------------
package scr1_memif_pkg;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_trc_fifo.sv
// ---------------------------------------------------------------------------
// scr1_trc_fifo
// Purpose : small synchronous FIFO with simultaneous push/pop. A push into a
//           full FIFO is accepted only when a pop happens in the same cycle.
//           A pop of an empty FIFO is ignored. clr empties the FIFO and takes
//           priority over push/pop. Head data comes straight from storage.
// Ports   : clk, rst_n (async active-low), clr (sync flush),
//           push/wdata, pop/rdata, empty, full.
// ---------------------------------------------------------------------------
module scr1_trc_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps the pointer legal even for non power-of-2 depths.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~clr;
    // A pop frees the slot this cycle, so push into a full FIFO is fine then.
    assign do_push = push & (~full | do_pop) & ~clr;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is reset so the head fields read as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule : scr1_trc_fifo

// File: rtl/scr1_imem_cmd_tracer.sv
// ---------------------------------------------------------------------------
// scr1_imem_cmd_tracer
// Purpose : passive snooper on the core-side IMEM interface. Pairs every
//           accepted fetch address with its later response, detects a marker
//           instruction in OKAY responses and queues {addr, timestamp}
//           records in a log FIFO drained by a valid/ready consumer. It never
//           drives or stalls the IMEM interface.
// Ports   : clk, rst_n (async active-low)
//           trc_en        capture enable (address tracking always runs)
//           trc_clr       sync flush of log FIFO, drop counter, sticky error
//           imem_req, imem_req_ack, imem_addr, imem_resp, imem_rdata (snooped)
//           log_vld/log_rdy/log_addr/log_ts   log FIFO head
//           log_drop_cnt  saturating count of records lost to a full FIFO
//           err_outst     sticky in-flight overflow / orphan response flag
// ---------------------------------------------------------------------------
module scr1_imem_cmd_tracer
    import scr1_memif_pkg::*;
    import scr1_imem_trc_pkg::*;
#(
    parameter int          OUTST_DEPTH   = 2,
    parameter int          LOG_DEPTH     = 8,
    parameter int          TS_WIDTH      = SCR1_TRC_TS_W,
    parameter logic [31:0] MATCH_PATTERN = 32'h1DD19963,
    parameter logic [31:0] MATCH_MASK    = 32'hFFFFFFFF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           trc_en,
    input  logic                           trc_clr,
    input  logic                           imem_req,
    input  logic                           imem_req_ack,
    input  logic [31:0]                    imem_addr,
    input  logic [1:0]                     imem_resp,
    input  logic [31:0]                    imem_rdata,
    output logic                           log_vld,
    input  logic                           log_rdy,
    output logic [31:0]                    log_addr,
    output logic [TS_WIDTH-1:0]            log_ts,
    output logic [SCR1_TRC_DROP_CNT_W-1:0] log_drop_cnt,
    output logic                           err_outst
);

    localparam int REC_W = 32 + TS_WIDTH;

    logic                           outst_push;
    logic                           outst_empty;
    logic                           outst_full;
    logic [31:0]                    outst_addr;
    logic                           resp_vld;
    logic                           resp_ok;
    logic                           rec_match;
    logic                           err_evt;

    logic                           log_push;
    logic                           log_pop;
    logic                           log_empty;
    logic                           log_full;
    logic [REC_W-1:0]               log_wdata;
    logic [REC_W-1:0]               log_rdata;

    logic [TS_WIDTH-1:0]            ts_q, ts_d;
    logic [SCR1_TRC_DROP_CNT_W-1:0] drop_q, drop_d;
    logic                           err_q, err_d;

    // Any non-IDLE code (including the unused 2'b11) retires a fetch, but only
    // an OKAY response may produce a record.
    assign outst_push = imem_req & imem_req_ack;
    assign resp_vld   = (imem_resp != SCR1_MEM_RESP_NOTRDY);
    assign resp_ok    = (imem_resp == SCR1_MEM_RESP_RDY_OK);

    scr1_trc_fifo #(
        .WIDTH (32),
        .DEPTH (OUTST_DEPTH)
    ) i_outst_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .push  (outst_push),
        .wdata (imem_addr),
        .pop   (resp_vld),
        .rdata (outst_addr),
        .empty (outst_empty),
        .full  (outst_full)
    );

    assign rec_match = resp_ok & ~outst_empty & trc_en
                     & ((imem_rdata & MATCH_MASK) == (MATCH_PATTERN & MATCH_MASK));

    // Overflow only counts when no response frees a slot in the same cycle.
    assign err_evt = (outst_push & outst_full & ~(resp_vld & ~outst_empty))
                   | (resp_vld & outst_empty);

    assign log_push  = rec_match & ~trc_clr;
    assign log_pop   = log_vld & log_rdy;
    assign log_wdata = {outst_addr, ts_q};

    scr1_trc_fifo #(
        .WIDTH (REC_W),
        .DEPTH (LOG_DEPTH)
    ) i_log_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (trc_clr),
        .push  (log_push),
        .wdata (log_wdata),
        .pop   (log_pop),
        .rdata (log_rdata),
        .empty (log_empty),
        .full  (log_full)
    );

    assign log_vld      = ~log_empty;
    assign log_addr     = log_rdata[REC_W-1:TS_WIDTH];
    assign log_ts       = log_rdata[TS_WIDTH-1:0];
    assign log_drop_cnt = drop_q;
    assign err_outst    = err_q;

    // Timestamp runs freely and ignores trc_clr; drop counter and sticky error
    // are cleared by trc_clr, which wins over a same-cycle event.
    always_comb begin
        ts_d   = ts_q + TS_WIDTH'(1);
        drop_d = drop_q;
        err_d  = err_q;
        if (trc_clr) begin
            drop_d = '0;
            err_d  = 1'b0;
        end else begin
            if (log_push & log_full & ~log_pop & (drop_q != '1)) begin
                drop_d = drop_q + SCR1_TRC_DROP_CNT_W'(1);
            end
            if (err_evt) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            ts_q   <= ts_d;
            drop_q <= drop_d;
            err_q  <= err_d;
        end
    end

endmodule : scr1_imem_cmd_tracer

// File: tb/tb_scr1_imem_cmd_tracer.sv
// ---------------------------------------------------------------------------
// tb_scr1_imem_cmd_tracer
// Directed bench for the IMEM command tracer: a linear sequence of steps in
// one initial block, with hand-computed expectations checked by immediate
// assertions. Inputs change #1 after the rising edge; outputs are sampled at
// that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_scr1_imem_cmd_tracer;

    localparam logic [31:0] PAT      = 32'h1DD19963;
    localparam logic [1:0]  R_IDLE   = 2'b00;
    localparam logic [1:0]  R_OK     = 2'b01;
    localparam logic [1:0]  R_ERR    = 2'b10;
    localparam logic [1:0]  R_RSVD   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        trc_en;
    logic        trc_clr;
    logic        imem_req;
    logic        imem_req_ack;
    logic [31:0] imem_addr;
    logic [1:0]  imem_resp;
    logic [31:0] imem_rdata;
    logic        log_vld;
    logic        log_rdy;
    logic [31:0] log_addr;
    logic [15:0] log_ts;
    logic [7:0]  log_drop_cnt;
    logic        err_outst;

    int          n_checks;
    int          n_errors;
    logic [15:0] tb_ts;
    logic [15:0] exp_ts;
    logic [31:0] exp_a;
    int          budget;
    logic        timeout;

    scr1_imem_cmd_tracer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trc_en       (trc_en),
        .trc_clr      (trc_clr),
        .imem_req     (imem_req),
        .imem_req_ack (imem_req_ack),
        .imem_addr    (imem_addr),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .log_vld      (log_vld),
        .log_rdy      (log_rdy),
        .log_addr     (log_addr),
        .log_ts       (log_ts),
        .log_drop_cnt (log_drop_cnt),
        .err_outst    (err_outst)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle counter: value seen during a cycle is the timestamp a
    // match in that cycle must carry.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_ts <= 16'h0000;
        else        tb_ts <= tb_ts + 16'h0001;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value to its expectation, count and report.
    task automatic checkOutput(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One accepted fetch lasting a single cycle.
    task automatic applyStimulus(input logic [31:0] addr);
        imem_req     = 1'b1;
        imem_req_ack = 1'b1;
        imem_addr    = addr;
        tick();
        imem_req     = 1'b0;
        imem_req_ack = 1'b0;
        imem_addr    = 32'h0;
    endtask

    // One response cycle; remembers the timestamp a match would record.
    task automatic respond(input logic [1:0] r, input logic [31:0] d);
        imem_resp  = r;
        imem_rdata = d;
        exp_ts     = tb_ts;
        tick();
        imem_resp  = R_IDLE;
        imem_rdata = 32'h0;
    endtask

    task automatic popLog();
        log_rdy = 1'b1;
        tick();
        log_rdy = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        trc_en       = 1'b1;
        trc_clr      = 1'b0;
        imem_req     = 1'b0;
        imem_req_ack = 1'b0;
        imem_addr    = 32'h0;
        imem_resp    = R_IDLE;
        imem_rdata   = 32'h0;
        log_rdy      = 1'b0;
        exp_ts       = 16'h0;
        timeout      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_log_vld", log_vld, 0);
        checkOutput("rst_log_addr", log_addr, 0);
        checkOutput("rst_log_ts", log_ts, 0);
        checkOutput("rst_drop_cnt", log_drop_cnt, 0);
        checkOutput("rst_err_outst", err_outst, 0);
        rst_n = 1'b1;
        tick();

        // 1. Single fetch, marker response two cycles later
        applyStimulus(32'h200);
        tick();
        imem_resp  = R_OK;
        imem_rdata = PAT;
        exp_ts     = tb_ts;
        checkOutput("t1_vld_before", log_vld, 0);
        tick();
        imem_resp  = R_IDLE;
        imem_rdata = 32'h0;
        checkOutput("t1_vld", log_vld, 1);
        checkOutput("t1_addr", log_addr, 32'h200);
        checkOutput("t1_ts", log_ts, exp_ts);
        popLog();
        checkOutput("t1_empty", log_vld, 0);

        // 2. Back-to-back fetches, only the second response matches
        imem_req     = 1'b1;
        imem_req_ack = 1'b1;
        imem_addr    = 32'h100;
        tick();
        imem_addr    = 32'h104;
        tick();
        imem_req     = 1'b0;
        imem_req_ack = 1'b0;
        respond(R_OK, 32'h00000013);
        checkOutput("t2_no_rec", log_vld, 0);
        respond(R_OK, PAT);
        checkOutput("t2_addr", log_addr, 32'h104);
        popLog();
        checkOutput("t2_one_rec", log_vld, 0);
        checkOutput("t2_err", err_outst, 0);

        // 3. Consumer stalled: 10 matches into an 8-entry log
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h1000 + 32'(4 * i));
            respond(R_OK, PAT);
        end
        checkOutput("t3_vld", log_vld, 1);
        checkOutput("t3_drop", log_drop_cnt, 2);
        checkOutput("t3_head", log_addr, 32'h1000);
        checkOutput("t3_hold", log_addr, 32'h1000);
        // match and pop in the same cycle while full
        applyStimulus(32'h2000);
        imem_resp  = R_OK;
        imem_rdata = PAT;
        log_rdy    = 1'b1;
        tick();
        imem_resp  = R_IDLE;
        imem_rdata = 32'h0;
        log_rdy    = 1'b0;
        checkOutput("t3_drop_same", log_drop_cnt, 2);
        for (int k = 0; k < 8; k++) begin
            exp_a = (k < 7) ? (32'h1004 + 32'(4 * k)) : 32'h2000;
            checkOutput("t3_drain_addr", log_addr, exp_a);
            popLog();
        end
        checkOutput("t3_drained", log_vld, 0);

        // 4. ERROR / reserved responses, orphan response, clear
        applyStimulus(32'h300);
        respond(R_ERR, PAT);
        checkOutput("t4_err_no_rec", log_vld, 0);
        applyStimulus(32'h304);
        respond(R_RSVD, PAT);
        checkOutput("t4_rsvd_no_rec", log_vld, 0);
        checkOutput("t4_no_err", err_outst, 0);
        respond(R_OK, PAT);
        checkOutput("t4_orphan_err", err_outst, 1);
        checkOutput("t4_orphan_no_rec", log_vld, 0);
        trc_clr = 1'b1;
        tick();
        trc_clr = 1'b0;
        checkOutput("t4_clr_err", err_outst, 0);
        checkOutput("t4_clr_drop", log_drop_cnt, 0);

        // Match in the trc_clr cycle is discarded, pairing stays aligned
        applyStimulus(32'h500);
        trc_clr = 1'b1;
        respond(R_OK, PAT);
        trc_clr = 1'b0;
        checkOutput("clr_discard", log_vld, 0);

        // 5. Capture disabled during a match
        applyStimulus(32'h400);
        trc_en = 1'b0;
        respond(R_OK, PAT);
        trc_en = 1'b1;
        checkOutput("t5_en_off", log_vld, 0);
        applyStimulus(32'h404);
        respond(R_OK, PAT);
        checkOutput("t5_pair", log_addr, 32'h404);
        popLog();

        // In-flight overflow: third fetch is lost
        applyStimulus(32'h600);
        applyStimulus(32'h604);
        checkOutput("ovf_none", err_outst, 0);
        applyStimulus(32'h608);
        checkOutput("ovf_err", err_outst, 1);
        respond(R_OK, PAT);
        respond(R_OK, PAT);
        checkOutput("ovf_head0", log_addr, 32'h600);
        popLog();
        checkOutput("ovf_head1", log_addr, 32'h604);
        popLog();
        trc_clr = 1'b1;
        tick();
        trc_clr = 1'b0;

        // 6. Timestamp wrap
        budget = 0;
        while (tb_ts != 16'hFFFE && budget < 70000) begin
            tick();
            budget++;
        end
        timeout = (budget >= 70000);
        checkOutput("t6_wait_timeout", timeout, 0);
        applyStimulus(32'h700);
        respond(R_OK, PAT);
        checkOutput("t6_addr", log_addr, 32'h700);
        checkOutput("t6_ts_max", log_ts, 16'hFFFF);
        popLog();
        applyStimulus(32'h704);
        respond(R_OK, PAT);
        checkOutput("t6_ts_wrap", log_ts, 16'h0002);
        popLog();

        // Reset mid-burst: one record queued, one fetch still in flight
        applyStimulus(32'h800);
        applyStimulus(32'h804);
        respond(R_OK, PAT);
        checkOutput("t6_pre_rst_vld", log_vld, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_vld", log_vld, 0);
        checkOutput("t6_rst_ts", log_ts, 0);
        tick();
        rst_n = 1'b1;
        tick();
        respond(R_OK, PAT);
        checkOutput("t6_stale_err", err_outst, 1);
        checkOutput("t6_stale_no_rec", log_vld, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_scr1_imem_cmd_tracer
